// File: rtl/change_trace_monitor.sv
// change_trace_monitor: per-channel shadow compare, round-robin issue of
// change records {ch, value, ts} into a first-word-fall-through record FIFO.
module change_trace_monitor #(
  parameter int NUM_CH     = 32,
  parameter int DATA_W     = 32,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CH*DATA_W-1:0]   snap_data,
  input  logic [NUM_CH-1:0]          snap_mask,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [CH_W-1:0]            rec_ch,
  output logic [DATA_W-1:0]          rec_data,
  output logic [TS_W-1:0]            rec_ts,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                drop_cnt,
  output logic                       primed
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0]   ts_q;
  logic              primed_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [AW-1:0]     wr_q, rd_q;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [15:0]       drop_q, drop_d;

  logic [DATA_W-1:0] shadow_q   [NUM_CH];
  logic [DATA_W-1:0] hold_val_q [NUM_CH];
  logic [TS_W-1:0]   hold_ts_q  [NUM_CH];

  logic [CH_W-1:0]   mem_ch   [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [TS_W-1:0]   mem_ts   [FIFO_DEPTH];

  logic [NUM_CH-1:0] chg;
  logic              found;
  logic [CH_W-1:0]   sel;
  logic [CH_W:0]     jw;
  logic [CH_W-1:0]   jj;
  logic              full, pop, issue;
  logic [16:0]       ndrop, drop_sum;

  // FIFO head is presented straight from storage
  assign rec_valid  = (lvl_q != '0);
  assign rec_ch     = mem_ch[rd_q];
  assign rec_data   = mem_data[rd_q];
  assign rec_ts     = mem_ts[rd_q];
  assign fifo_level = lvl_q;
  assign drop_cnt   = drop_q;
  assign primed     = primed_q;

  assign full  = (lvl_q == LW'(FIFO_DEPTH));
  assign pop   = rec_valid && rec_ready;
  assign issue = en && found && (!full || pop);

  // a monitored channel changed against its shadow while tracing
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chg[i] = en && primed_q && snap_mask[i] &&
               (snap_data[i*DATA_W +: DATA_W] != shadow_q[i]);
    end
  end

  // first pending channel at or after rr_q, circular
  always_comb begin
    found = 1'b0;
    sel   = '0;
    jw    = '0;
    jj    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      jw = {1'b0, rr_q} + (CH_W+1)'(k);
      if (jw >= (CH_W+1)'(NUM_CH)) begin
        jw = jw - (CH_W+1)'(NUM_CH);
      end
      jj = jw[CH_W-1:0];
      if (!found && pend_q[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  // pending flags, coalesced-change count and pointer/level next state
  always_comb begin
    pend_d = pend_q;
    ndrop  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (1'b1)
        !en: begin
          pend_d[i] = 1'b0;
        end
        chg[i]: begin
          pend_d[i] = 1'b1;
          if (pend_q[i] && !(issue && sel == CH_W'(i))) begin
            ndrop = ndrop + 17'd1;
          end
        end
        default: begin
          if (issue && sel == CH_W'(i)) begin
            pend_d[i] = 1'b0;
          end
        end
      endcase
    end
    drop_sum = {1'b0, drop_q} + ndrop;
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    rr_d     = (sel == CH_W'(NUM_CH-1)) ? '0 : sel + CH_W'(1);
    lvl_d    = lvl_q;
    unique case ({issue, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // control state: timestamp, priming, pending, arbiter and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      primed_q <= 1'b0;
      pend_q   <= '0;
      rr_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      primed_q <= en;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      lvl_q    <= lvl_d;
      if (issue) begin
        rr_q <= rr_d;
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

  // datapath storage: shadow, per-channel hold and record FIFO
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (en) begin
        shadow_q[i] <= snap_data[i*DATA_W +: DATA_W];
      end
      if (chg[i]) begin
        hold_val_q[i] <= snap_data[i*DATA_W +: DATA_W];
        hold_ts_q[i]  <= ts_q;
      end
    end
    if (issue) begin
      mem_ch[wr_q]   <= sel;
      mem_data[wr_q] <= hold_val_q[sel];
      mem_ts[wr_q]   <= hold_ts_q[sel];
    end
  end

endmodule

// File: doc/change_trace_monitor.md
Name: change_trace_monitor

Overview:
- Synthesizable, parametrised state-change tracer for architectural state: register files, CSRs, memory windows.
- Compares NUM_CH channel snapshots against a shadow copy every cycle. Each change becomes a record {channel, new value, timestamp}.
- Records pass through a round-robin arbiter into a FIFO with a valid/ready drain port.
- Feeds the debug/trace UART path; replaces simulation-only change logging.

Parameters:
- NUM_CH, 32, number of monitored channels.
- DATA_W, 32, width of each channel value.
- TS_W, 32, timestamp counter width.
- FIFO_DEPTH, 16, output record FIFO depth; power of two, ≥2.
- CH_W, $clog2(NUM_CH), channel index width (derived, do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  tracing enable; first cycle high primes shadow.
- snap_data  in  NUM_CH*DATA_W  flattened channel values; channel i at [i*DATA_W +: DATA_W].
- snap_mask  in  NUM_CH  per-channel monitor enable.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  consumer accepts head.
- rec_ch  out  CH_W  head record channel index.
- rec_data  out  DATA_W  head record value.
- rec_ts  out  TS_W  head record timestamp.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- drop_cnt  out  16  coalesced-change counter, saturating at 16'hFFFF.
- primed  out  1  shadow valid, tracing active.

Behaviour:
- Reset (rst=1 at edge):
  - ts, primed, pending[], rr_ptr, FIFO pointers, fifo_level, drop_cnt cleared to 0.
  - rec_valid=0.
  - Shadow and hold registers are don't-care.
- ts: free-running from first cycle after reset; +1 per cycle; wraps at 2^TS_W. Runs regardless of en.
- Priming:
  - en=1 && primed=0: shadow <= snap_data, primed <= 1, no records generated.
  - en=0: primed <= 0; pending[] cleared; FIFO contents retained and still drainable.
- Change detect (primed=1, en=1): chg[i] = snap_mask[i] && (snap_data_i !== shadow[i]).
- For each chg[i], in the same edge:
  - shadow[i] <= new value.
  - hold_val[i] <= new value; hold_ts[i] <= ts.
  - pending[i] <= 1.
  - If pending[i] was already 1 and not issued this cycle, drop_cnt +1 (saturating). Older value is lost; newest wins.
- Masked channels (snap_mask[i]=0): shadow still tracks the input; no pending is set.
- Arbiter (one issue per cycle):
  - Selects the first pending channel at or after rr_ptr (circular).
  - Issues only when FIFO not full, or full with a pop in the same cycle.
  - Issue writes {idx, hold_val, hold_ts} to FIFO tail and clears pending[idx]; rr_ptr <= idx+1 mod NUM_CH.
  - If chg[idx] is also set that cycle: new value is held and pending stays 1; this is not a drop.
- FIFO:
  - First-word-fall-through; rec_* reflect the head combinationally from storage.
  - Pop when rec_valid && rec_ready.
  - Push and pop in the same cycle leave the level unchanged.
  - Full: arbiter stalls; changes coalesce in hold registers.
- Latency: change seen at edge N → earliest rec_valid at edge N+2 (hold at N, FIFO write at N+1), with rec_ts = ts value at edge N.
- rec_* hold stable while rec_valid && !rec_ready.
- Reset mid-operation: all pending, FIFO and counters discarded; the next enable re-primes.

Test Plan:
- Prime, then single change: rst 2 cycles; en=1, mask=all; change ch5 to 0xDEADBEEF at ts=10 → one record {5, 0xDEADBEEF, 10}, rec_valid two cycles later; drop_cnt=0.
- Simultaneous changes: ch3, ch7, ch30 change in one cycle, rec_ready=1 → three records in order 3, 7, 30 on consecutive cycles, identical ts.
- Back-pressure and coalescing: rec_ready=0; FIFO_DEPTH+1 distinct channels change, then ch0 changes twice more → fifo_level=16, drop_cnt=1, ch0's last value delivered after release.
- Masking and priming: snap_mask[2]=0 and ch2 toggles → no records; first en cycle with all-nonzero data → no records; then en=0/1 re-prime → no spurious records.
- Round-robin fairness: ch1 and ch2 change every cycle, FIFO never full → records alternate 1, 2, 1, 2; neither starves.
- Reset mid-stream: FIFO holds 5 records, assert rst 1 cycle → rec_valid=0, fifo_level=0, drop_cnt=0, ts restarts at 0.
